ram_bwe_rmw: RTL
================

// Module: ram_bwe_rmw
//
// PURPOSE
//  Parametrised single-port RAM with per-byte write enables, built over a word-write-only storage array.
//  Successor to the fixed 128x32 RAM: depth and word width are parameters, and a valid/ready request port plus a response port are added.
//  Partial-byte writes are implemented as an internal read-modify-write (RMW), so the per-byte WE works on macros that only write whole words.
//  Sits between the FSIC user-project buses and on-chip buffer storage.
//
// PARAMETERS
//  WSIZE   4  bytes per word; data width = WSIZE*8
//  AWIDTH  7  address bits; DEPTH = 2**AWIDTH words
//
// PORTS
//  CLK        in   1         single clock; all logic on rising edge
//  RST        in   1         synchronous reset, active-high
//  req_valid  in   1         request present
//  req_ready  out  1         block can accept a request this cycle
//  req_we     in   WSIZE     byte write enables; all-zero means read
//  req_addr   in   AWIDTH    word address
//  req_wdata  in   WSIZE*8   write data, byte i = [8*i +: 8]
//  rsp_valid  out  1         one-cycle pulse: rsp_rdata is valid
//  rsp_rdata  out  WSIZE*8   read data
//  busy       out  1         RMW in progress (state != IDLE)
//
// BEHAVIOUR
//  - Reset values: req_ready=0 while RST=1, then 1; rsp_valid=0; rsp_rdata=0; busy=0; state=IDLE.
//  - Memory contents are not reset.
//  - Accept condition: req_valid & req_ready. Requests are ignored when this is not true.
//  - States:
//    - IDLE: req_ready=1.
//    - RMW_RD: req_ready=0, busy=1.
//    - RMW_WR: req_ready=0, busy=1.
//  - Read (req_we==0) in IDLE:
//    - Array read is issued in the accept cycle.
//    - rsp_valid=1 and rsp_rdata=mem[addr] in the next cycle (latency 1).
//    - Back-to-back reads sustain 1 per cycle.
//  - Full write (req_we all ones) in IDLE:
//    - Word is written at the accept edge. No response is generated; stay in IDLE.
//  - Partial write (req_we neither zero nor all ones):
//    - The accept cycle latches addr, we and wdata and issues an array read. Go to RMW_RD.
//    - RMW_RD: array data is valid. Merge: byte i = we[i] ? wdata byte i : old byte i. Register the result. Go to RMW_WR.
//    - RMW_WR: write the merged word. Go to IDLE.
//    - The next request can be accepted 3 cycles after the accept cycle. No rsp_valid is generated.
//  - rsp_valid has no backpressure. rsp_rdata holds its last value until the next read response.
//  - Read-after-write: a read accepted in the cycle after a write completes returns the new data. No bypass is needed because writes finish before req_ready rises.
//  - Address is AWIDTH bits, so every address is in range and there is no wrap logic.
//  - RST asserted during RMW_RD or RMW_RD→RMW_WR:
//    - Abort; the write is not performed.
//    - A reset at the RMW_WR edge itself still completes the write.
//    - Next state = IDLE, rsp_valid=0.
//  - RST asserted in the cycle after a read accept suppresses rsp_valid.
//  - Array enable is asserted only in accept and RMW_WR cycles (power).
//
// STRUCTURE
//  - Package ram_bwe_pkg:
//    - State enum {IDLE, RMW_RD, RMW_WR}.
//    - Function classifying req_we as READ, FULL or PARTIAL.
//  - Sub-module sram_word_array (AWIDTH, WSIZE):
//    - Ports CLK, EN, WE (1 bit, full word), A, D, Q.
//    - 1-cycle registered read.
//    - Behavioural reg array; this is the single point later swapped for a PDK macro.
//  - Top level: FSM, request capture registers, byte-merge mux, response registers.
//
// TESTING
//  1. Reset with RST high for 2 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0 during reset; req_ready=1 in the first cycle after.
//  2. Full write A=0x05, D=0xDEADBEEF, WE=4'hF; then read A=0x05 -> rsp_valid one cycle after the read accept, rdata=0xDEADBEEF.
//  3. Partial write A=0x05, WE=4'b0101, D=0x11223344 after test 2:
//     - req_ready low for 2 cycles; busy high for 2 cycles.
//     - A subsequent read returns 0xDE22BE44.
//  4. Reads to A=0x7F, 0x00, 0x7F on consecutive cycles -> three consecutive rsp_valid pulses with the matching data.
//  5. Partial write to A=0x10 (old 0xAAAAAAAA, WE=4'b0001, D=0x55); RST pulses during RMW_RD:
//     - Read of 0x10 after reset returns 0xAAAAAAAA.
//     - busy=0 after reset.
//  6. req_valid held high with a partial write followed by a read -> the read is accepted exactly 3 cycles after the write; no request is lost or duplicated.

Source files
------------

// File: rtl/ram_bwe_rmw_pkg.sv
// Shared types for the byte-write-enable RAM: controller states and
// request classification derived from the byte-enable mask.
package ram_bwe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        READ    = 2'd0,
        FULL    = 2'd1,
        PARTIAL = 2'd2
    } req_kind_e;

    // Widest byte-enable mask the classifier understands; callers zero-extend.
    localparam int MAX_WSIZE = 16;

    function automatic req_kind_e classify(input logic [MAX_WSIZE-1:0] we,
                                           input int wsize);
        logic any_set;
        logic all_set;
        any_set = 1'b0;
        all_set = 1'b1;
        for (int i = 0; i < MAX_WSIZE; i++) begin
            if (i < wsize) begin
                any_set = any_set | we[i];
                all_set = all_set & we[i];
            end
        end
        if (!any_set)
            return READ;
        else if (all_set)
            return FULL;
        else
            return PARTIAL;
    endfunction

endpackage

// File: rtl/ram_bwe_rmw_if.sv
// Request/response bundle of the byte-write-enable RAM.
interface ram_bwe_rmw_if #(
    parameter int WSIZE  = 4,
    parameter int AWIDTH = 7
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WSIZE-1:0]     req_we;
    logic [AWIDTH-1:0]    req_addr;
    logic [WSIZE*8-1:0]   req_wdata;
    logic                 rsp_valid;
    logic [WSIZE*8-1:0]   rsp_rdata;
    logic                 busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/ram_bwe_rmw_sram.sv
// Word-write-only storage with a registered read port; the one place a
// PDK macro replaces the behavioural array.
module sram_word_array #(
    parameter int AWIDTH = 7,
    parameter int WSIZE  = 4
) (
    input  logic                CLK,
    input  logic                EN,
    input  logic                WE,
    input  logic [AWIDTH-1:0]   A,
    input  logic [WSIZE*8-1:0]  D,
    output logic [WSIZE*8-1:0]  Q
);
    logic [WSIZE*8-1:0] mem [2**AWIDTH];

    always_ff @(posedge CLK) begin
        if (EN) begin
            if (WE)
                mem[A] <= D;
            else
                Q <= mem[A];
        end
    end
endmodule

// File: rtl/ram_bwe_rmw.sv
// Single-port RAM with per-byte write enables; partial writes become an
// internal read-modify-write over a word-write-only array.
module ram_bwe_rmw
    import ram_bwe_pkg::*;
#(
    parameter int WSIZE  = 4,
    parameter int AWIDTH = 7
) (
    input  logic         CLK,
    input  logic         RST,
    ram_bwe_rmw_if.slave bus
);
    localparam int DW = WSIZE * 8;

    state_e            state, state_nxt;
    req_kind_e         kind;
    logic              acc;

    logic [AWIDTH-1:0] addr_p0;
    logic [WSIZE-1:0]  we_p0;
    logic [DW-1:0]     wdata_p0;
    logic [DW-1:0]     merged_p1;
    logic              vld_p1;
    logic [DW-1:0]     rdata_hold;

    logic              arr_en;
    logic              arr_we;
    logic [AWIDTH-1:0] arr_a;
    logic [DW-1:0]     arr_d;
    logic [DW-1:0]     arr_q;

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0]    old_w,
                                                 input logic [DW-1:0]    new_w,
                                                 input logic [WSIZE-1:0] we);
        logic [DW-1:0] res;
        for (int i = 0; i < WSIZE; i++)
            res[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return res;
    endfunction

    assign kind = classify(MAX_WSIZE'(bus.req_we), WSIZE);
    assign acc  = bus.req_valid && (state == IDLE) && !RST;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc && kind == PARTIAL) state_nxt = RMW_RD;
            RMW_RD:  state_nxt = RMW_WR;
            RMW_WR:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The array is only enabled on accepts and the RMW write-back cycle.
    always_comb begin
        bus.req_ready = (state == IDLE) && !RST;
        bus.busy      = (state != IDLE);
        arr_en        = 1'b0;
        arr_we        = 1'b0;
        arr_a         = bus.req_addr;
        arr_d         = bus.req_wdata;
        if (acc) begin
            arr_en = 1'b1;
            arr_we = (kind == FULL);
        end
        if (state == RMW_WR) begin
            arr_en = 1'b1;
            arr_we = 1'b1;
            arr_a  = addr_p0;
            arr_d  = merged_p1;
        end
    end

    sram_word_array #(
        .AWIDTH (AWIDTH),
        .WSIZE  (WSIZE)
    ) u_array (
        .CLK (CLK),
        .EN  (arr_en),
        .WE  (arr_we),
        .A   (arr_a),
        .D   (arr_d),
        .Q   (arr_q)
    );

    // ---- p0: request capture at accept ----
    always_ff @(posedge CLK) begin
        if (acc) begin
            addr_p0  <= bus.req_addr;
            we_p0    <= bus.req_we;
            wdata_p0 <= bus.req_wdata;
        end
    end

    // ---- p1: merge old word with new bytes while in RMW_RD ----
    always_ff @(posedge CLK) begin
        if (state == RMW_RD)
            merged_p1 <= byte_merge(arr_q, wdata_p0, we_p0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_p1     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            vld_p1 <= acc && (kind == READ);
            if (vld_p1)
                rdata_hold <= arr_q;
        end
    end

    // Response fires in the cycle after a read accept; a reset in that
    // cycle swallows it. Between responses the last read word is held.
    assign bus.rsp_valid = vld_p1 && !RST;
    assign bus.rsp_rdata = bus.rsp_valid ? arr_q : rdata_hold;
endmodule
